// File: rtl/pond_stream_pkg.sv
// Shared types and default widths for the pond read-side stream adapter.
// Holds the capture FSM state encoding used by pond_stream_out.
package pond_stream_pkg;

   localparam int DATA_WIDTH_DEF   = 16;
   localparam int CONFIG_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO: one push and one pop per cycle, head visible one cycle after push.
// Push while full is accepted only alongside a pop; otherwise the word is dropped.
module stream_fifo #(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_acc, pop_acc;

   assign empty_o  = (count_q == '0);
   assign full_o   = (count_q == (AW+1)'(DEPTH));
   assign pop_acc  = pop_i & ~empty_o;
   assign push_acc = push_i & (~full_o | pop_acc);
   assign count_o  = count_q;
   assign head_o   = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_acc)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
      end
   end

   // Storage needs no reset: head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (push_acc && !clr_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/pond_stream_out.sv
// Captures pond read data on 2-D scheduled cycles into a FIFO, drained as ready/valid.
// Capture-to-valid latency 1 cycle; a full FIFO without a pop drops the word and sets overflow.
module pond_stream_out
   import pond_stream_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int CONFIG_WIDTH = CONFIG_WIDTH_DEF,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clk_en,
   input  logic                          flush,
   input  logic [CONFIG_WIDTH-1:0]       cycle_count,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic [1:0]                    dimensionality,
   input  logic [CONFIG_WIDTH-1:0]       ranges_0,
   input  logic [CONFIG_WIDTH-1:0]       ranges_1,
   input  logic [CONFIG_WIDTH-1:0]       sched_starting_addr,
   input  logic [CONFIG_WIDTH-1:0]       sched_strides_0,
   input  logic [CONFIG_WIDTH-1:0]       sched_strides_1,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          valid_out,
   input  logic                          ready_in,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          done,
   output logic                          overflow
);

   state_e                  state_q, state_d, state_eff;
   logic [CONFIG_WIDTH-1:0] i0_q, i0_d, i1_q, i1_d;
   logic [CONFIG_WIDTH-1:0] sched_addr_q, sched_addr_d, next_cap;
   logic                    ovf_q, ovf_d;
   logic                    capture, last_cap, pop, fifo_full, fifo_empty, fifo_clr;

   // Reset/flush land in RUN; with zero loop levels RUN reads as IDLE, so the
   // asynchronous reset value does not depend on a configuration input.
   always_comb begin
      state_eff = state_q;
      if (state_q == ST_RUN && dimensionality == 2'd0) state_eff = ST_IDLE;
   end

   assign next_cap  = sched_starting_addr + sched_addr_q;
   assign capture   = clk_en & ~flush & (state_eff == ST_RUN) & (cycle_count == next_cap);
   assign last_cap  = (i0_q == ranges_0) && (dimensionality == 2'd1 || i1_q == ranges_1);
   assign valid_out = ~fifo_empty;
   assign pop       = clk_en & ~flush & valid_out & ready_in;
   assign fifo_clr  = clk_en & flush;
   assign overflow  = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_RUN;
      else if (clk_en) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_RUN;
      end else begin
         case (state_eff)
            ST_RUN:  if (capture && last_cap) state_d = ST_DONE;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      done = (state_eff != ST_RUN);
   end

   always_comb begin
      i0_d         = i0_q;
      i1_d         = i1_q;
      sched_addr_d = sched_addr_q;
      ovf_d        = ovf_q;
      if (flush) begin
         i0_d         = '0;
         i1_d         = '0;
         sched_addr_d = '0;
         ovf_d        = 1'b0;
      end else if (capture) begin
         if (i0_q != ranges_0) begin
            i0_d         = i0_q + CONFIG_WIDTH'(1);
            sched_addr_d = sched_addr_q + sched_strides_0;
         end else begin
            i0_d         = '0;
            i1_d         = i1_q + CONFIG_WIDTH'(1);
            sched_addr_d = sched_addr_q + sched_strides_1;
         end
         if (fifo_full && !pop) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i0_q         <= '0;
         i1_q         <= '0;
         sched_addr_q <= '0;
         ovf_q        <= 1'b0;
      end else if (clk_en) begin
         i0_q         <= i0_d;
         i1_q         <= i1_d;
         sched_addr_q <= sched_addr_d;
         ovf_q        <= ovf_d;
      end
   end

   stream_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (fifo_clr),
      .push_i     (capture),
      .push_dat_i (data_in),
      .pop_i      (pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count),
      .head_o     (data_out)
   );

endmodule

// File: tb/tb_pond_stream_out.sv
// Randomized bench for pond_stream_out against a queue-based schedule model.
module tb_pond_stream_out;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, clk_en, flush, ready_in;
   logic [15:0] cycle_count, data_in, ranges_0, ranges_1, start, s0, s1;
   logic [1:0]  dim;
   logic [15:0] data_out;
   logic        valid_out, done, overflow;
   logic [2:0]  fifo_count;

   int total = 0;
   int bad   = 0;

   logic [15:0] m_sched[$];
   logic [15:0] m_q[$];
   int          m_k;
   bit          m_ovf;

   pond_stream_out #(.DATA_WIDTH(16), .CONFIG_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .clk_en              (clk_en),
      .flush               (flush),
      .cycle_count         (cycle_count),
      .data_in             (data_in),
      .dimensionality      (dim),
      .ranges_0            (ranges_0),
      .ranges_1            (ranges_1),
      .sched_starting_addr (start),
      .sched_strides_0     (s0),
      .sched_strides_1     (s1),
      .data_out            (data_out),
      .valid_out           (valid_out),
      .ready_in            (ready_in),
      .fifo_count          (fifo_count),
      .done                (done),
      .overflow            (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
      end
   endtask

   // Capture cycle of iteration (i0,i1): start + i1*(r0*s0+s1) + i0*s0, mod 2^16.
   function automatic void build_sched();
      int n1;
      m_sched.delete();
      if (dim == 2'd0) return;
      n1 = (dim == 2'd1) ? 0 : int'(ranges_1);
      for (int i1 = 0; i1 <= n1; i1++)
         for (int i0 = 0; i0 <= int'(ranges_0); i0++)
            m_sched.push_back(16'(int'(start) + i1 * (int'(ranges_0) * int'(s0) + int'(s1))
                                  + i0 * int'(s0)));
   endfunction

   function automatic void model_edge();
      bit pop, cap;
      pop = clk_en && !flush && m_q.size() > 0 && ready_in;
      cap = clk_en && !flush && m_k < m_sched.size() && cycle_count == m_sched[m_k];
      if (clk_en && flush) begin
         m_q.delete();
         m_k   = 0;
         m_ovf = 1'b0;
      end else if (clk_en) begin
         if (pop) void'(m_q.pop_front());
         if (cap) begin
            if (m_q.size() < DEPTH) m_q.push_back(data_in);
            else m_ovf = 1'b1;
            m_k++;
         end
      end
   endfunction

   task automatic check_outputs();
      chk_val("valid", 32'(valid_out), 32'(m_q.size() > 0));
      chk_val("data", 32'(data_out), 32'((m_q.size() > 0) ? m_q[0] : 16'd0));
      chk_val("count", 32'(fifo_count), 32'(m_q.size()));
      chk_val("done", 32'(done), 32'((dim == 2'd0) || (m_k == m_sched.size())));
      chk_val("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   // rmode: 0 ready, 1 stalled, 2 random, 3 ready from cycle 4.
   // emode: 0 enabled, 1 random enable, 2 disabled at cycle 5 while the counter runs on.
   task automatic run(input int n, input int rmode, input int emode, input bit rnd_data);
      for (int i = 0; i < n; i++) begin
         case (emode)
            0:       clk_en = 1'b1;
            1:       clk_en = ($urandom_range(0, 4) != 0);
            default: clk_en = (cycle_count != 16'd5);
         endcase
         case (rmode)
            0:       ready_in = 1'b1;
            1:       ready_in = 1'b0;
            2:       ready_in = 1'($urandom_range(0, 1));
            default: ready_in = (cycle_count >= 16'd4);
         endcase
         data_in = rnd_data ? 16'($urandom) : cycle_count;
         step();
         if (clk_en || emode == 2) cycle_count = cycle_count + 16'd1;
      end
   endtask

   task automatic cfg(input logic [1:0] d, input int r0, input int r1, input int st,
                      input int a0, input int a1);
      dim      = d;
      ranges_0 = 16'(r0);
      ranges_1 = 16'(r1);
      start    = 16'(st);
      s0       = 16'(a0);
      s1       = 16'(a1);
      build_sched();
      flush    = 1'b1;
      clk_en   = 1'b1;
      ready_in = 1'b0;
      data_in  = 16'($urandom);
      step();
      flush       = 1'b0;
      cycle_count = 16'd0;
   endtask

   initial begin
      rst = 1'b1; clk_en = 1'b1; flush = 1'b0; ready_in = 1'b1;
      cycle_count = 16'd0; data_in = 16'd0;
      dim = 2'd0; ranges_0 = 16'd3; ranges_1 = 16'd0; start = 16'd10; s0 = 16'd2; s1 = 16'd0;
      #1;
      chk_val("rst_done_dim0", 32'(done), 32'd1);
      dim = 2'd1;
      repeat (2) @(posedge clk);
      #1;
      chk_val("rst_valid", 32'(valid_out), 32'd0);
      chk_val("rst_data", 32'(data_out), 32'd0);
      chk_val("rst_count", 32'(fifo_count), 32'd0);
      chk_val("rst_overflow", 32'(overflow), 32'd0);
      chk_val("rst_done_dim1", 32'(done), 32'd0);
      rst = 1'b0;
      m_q.delete(); m_k = 0; m_ovf = 1'b0;
      build_sched();

      // Linear schedule, data_in mirrors the cycle counter.
      run(22, 0, 0, 1'b0);
      // 2-D wrap: captures at 0, 1, 6, 7.
      cfg(2'd2, 1, 1, 0, 1, 5);
      run(12, 0, 0, 1'b1);
      // Backpressure overflow, then drain.
      cfg(2'd1, 5, 0, 0, 1, 0);
      run(10, 1, 0, 1'b1);
      run(8, 0, 0, 1'b1);
      // Full FIFO with simultaneous push and pop.
      cfg(2'd1, 7, 0, 0, 1, 0);
      run(16, 3, 0, 1'b1);
      // clk_en low across the capture at cycle 5.
      cfg(2'd1, 3, 0, 2, 3, 0);
      run(20, 0, 2, 1'b1);
      // Flush mid-run with words buffered, then restart.
      cfg(2'd1, 4, 0, 1, 1, 0);
      run(4, 1, 0, 1'b1);
      cfg(2'd1, 4, 0, 1, 1, 0);
      run(12, 2, 0, 1'b1);
      // Random configurations including dimensionality 0.
      for (int r = 0; r < 6; r++) begin
         cfg(2'($urandom_range(0, 2)), $urandom_range(0, 3), $urandom_range(0, 2),
             $urandom_range(0, 8), $urandom_range(1, 3), $urandom_range(1, 6));
         run(60, 2, 1, 1'b1);
      end
      // Asynchronous reset between edges with two words buffered.
      cfg(2'd1, 7, 0, 0, 1, 0);
      run(2, 1, 0, 1'b1);
      #3 rst = 1'b1;
      #1;
      chk_val("arst_valid", 32'(valid_out), 32'd0);
      chk_val("arst_count", 32'(fifo_count), 32'd0);
      chk_val("arst_data", 32'(data_out), 32'd0);
      chk_val("arst_done", 32'(done), 32'd0);
      m_q.delete(); m_k = 0; m_ovf = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      cycle_count = 16'd0;
      run(12, 2, 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
